// File: rtl/screen_switcher.sv
// screen_switcher: frame-synchronous N-way VGA source selector with optional fade-out/fade-in.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   src_hcount/src_vcount   per-source counters, channel i at [i*HC_W +: HC_W]
//   src_hsync/vsync/hblnk/vblnk  per-source timing bits, channel i at bit i
//   src_rgb                 per-source colour, channel i at [i*RGB_W +: RGB_W]
//   sel_req/sel_valid/sel_ready  source-change request handshake
//   out_*                   registered timing and attenuated colour of the displayed source
//   active_sel              displayed source
//   switching               high while a change is in progress
module screen_switcher #(
  parameter int N_SRC = 5,
  parameter int SEL_W = $clog2(N_SRC),
  parameter int HC_W = 11,
  parameter int RGB_W = 12,
  parameter int FADE_STEPS = 4,
  parameter int DEFAULT_SRC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC*HC_W-1:0]  src_hcount,
  input  logic [N_SRC*HC_W-1:0]  src_vcount,
  input  logic [N_SRC-1:0]       src_hsync,
  input  logic [N_SRC-1:0]       src_vsync,
  input  logic [N_SRC-1:0]       src_hblnk,
  input  logic [N_SRC-1:0]       src_vblnk,
  input  logic [N_SRC*RGB_W-1:0] src_rgb,
  input  logic [SEL_W-1:0]       sel_req,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic [HC_W-1:0]        out_hcount,
  output logic [HC_W-1:0]        out_vcount,
  output logic                   out_hsync,
  output logic                   out_vsync,
  output logic                   out_hblnk,
  output logic                   out_vblnk,
  output logic [RGB_W-1:0]       out_rgb,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   switching
);
  localparam int C_W = RGB_W / 3;
  localparam int ATT_W = FADE_STEPS > 0 ? $clog2(FADE_STEPS + 1) : 1;
  typedef enum logic [2:0] {IDLE, FADE_OUT, CUT, SWAP, FADE_IN} state_t;
  state_t state, state_d;
  logic [HC_W-1:0] hc [N_SRC];
  logic [HC_W-1:0] vc [N_SRC];
  logic [RGB_W-1:0] rgb [N_SRC];
  logic [RGB_W-1:0] rgb_att;
  logic [SEL_W-1:0] pending, pending_d, active_d;
  logic [ATT_W-1:0] att, att_d;
  logic vb_prev, vb_prev_d, fb, take, blank;
  genvar i, c;
  generate
    for (i = 0; i < N_SRC; i++) begin : g_unpack
      assign hc[i] = src_hcount[i*HC_W +: HC_W];
      assign vc[i] = src_vcount[i*HC_W +: HC_W];
      assign rgb[i] = src_rgb[i*RGB_W +: RGB_W];
    end
    for (c = 0; c < 3; c++) begin : g_comp
      assign rgb_att[c*C_W +: C_W] = rgb[active_sel][c*C_W +: C_W] >> att;
    end
  endgenerate
  assign sel_ready = state == IDLE;
  assign blank = src_hblnk[active_sel] | src_vblnk[active_sel];
  assign fb = src_vblnk[active_sel] & ~vb_prev;
  // only a request naming a different, existing source starts a switch; others are just consumed
  assign take = sel_valid && sel_ready && sel_req != active_sel && {1'b0, sel_req} < (SEL_W + 1)'(N_SRC);
  always_comb begin
    state_d = state;
    att_d = att;
    pending_d = pending;
    active_d = active_sel;
    vb_prev_d = src_vblnk[active_sel];
    case (state)
      IDLE: begin
        att_d = '0;
        if (take) begin
          pending_d = sel_req;
          state_d = FADE_STEPS == 0 ? CUT : FADE_OUT;
        end
      end
      FADE_OUT: if (fb) begin
        att_d = att + 1'b1;
        state_d = att_d == ATT_W'(FADE_STEPS) ? SWAP : FADE_OUT;
      end
      CUT: state_d = fb ? SWAP : CUT;
      SWAP: begin
        active_d = pending;
        // edge detector restarts from the new source's level so the swap itself is not a frame boundary
        vb_prev_d = src_vblnk[pending];
        state_d = FADE_STEPS == 0 ? IDLE : FADE_IN;
      end
      FADE_IN: if (fb) begin
        att_d = att - 1'b1;
        state_d = att_d == '0 ? IDLE : FADE_IN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      att <= '0;
      pending <= SEL_W'(DEFAULT_SRC);
      active_sel <= SEL_W'(DEFAULT_SRC);
      vb_prev <= 1'b0;
      switching <= 1'b0;
    end else begin
      state <= state_d;
      att <= att_d;
      pending <= pending_d;
      active_sel <= active_d;
      vb_prev <= vb_prev_d;
      switching <= state_d != IDLE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_hcount <= '0;
      out_vcount <= '0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_hblnk <= 1'b0;
      out_vblnk <= 1'b0;
      out_rgb <= '0;
    end else begin
      out_hcount <= hc[active_sel];
      out_vcount <= vc[active_sel];
      out_hsync <= src_hsync[active_sel];
      out_vsync <= src_vsync[active_sel];
      out_hblnk <= src_hblnk[active_sel];
      out_vblnk <= src_vblnk[active_sel];
      out_rgb <= blank ? '0 : rgb_att;
    end
endmodule

// File: tb/tb_screen_switcher.sv
// tb_screen_switcher: directed checks of fade switching, hard cut, no-op requests, stalling and async reset.
module tb_screen_switcher;
  localparam int N = 5;
  localparam int HW = 11;
  localparam int RW = 12;
  localparam int SW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vb = 1'b0;
  logic [N*HW-1:0] src_hcount, src_vcount;
  logic [N-1:0] src_hsync, src_vsync, src_hblnk, src_vblnk;
  logic [N*RW-1:0] src_rgb;
  logic [SW-1:0] sel_req = '0, sel_req_c = '0;
  logic sel_valid = 1'b0, sel_valid_c = 1'b0;
  logic a_ready, a_hsync, a_vsync, a_hblnk, a_vblnk, a_switching;
  logic [HW-1:0] a_hcount, a_vcount;
  logic [RW-1:0] a_rgb;
  logic [SW-1:0] a_active;
  logic c_ready, c_hsync, c_vsync, c_hblnk, c_vblnk, c_switching;
  logic [HW-1:0] c_hcount, c_vcount;
  logic [RW-1:0] c_rgb;
  logic [SW-1:0] c_active;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign src_vblnk = {N{vb}};
  assign src_hblnk = '0;
  assign src_hsync = 5'b00100;
  assign src_vsync = 5'b01000;
  assign src_rgb = {12'h123, 12'h5A3, 12'h888, 12'hABC, 12'hFFF};
  screen_switcher #(.N_SRC(N), .FADE_STEPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_hcount(src_hcount), .src_vcount(src_vcount),
    .src_hsync(src_hsync), .src_vsync(src_vsync), .src_hblnk(src_hblnk), .src_vblnk(src_vblnk),
    .src_rgb(src_rgb), .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(a_ready),
    .out_hcount(a_hcount), .out_vcount(a_vcount), .out_hsync(a_hsync), .out_vsync(a_vsync),
    .out_hblnk(a_hblnk), .out_vblnk(a_vblnk), .out_rgb(a_rgb), .active_sel(a_active),
    .switching(a_switching));
  screen_switcher #(.N_SRC(N), .FADE_STEPS(0)) dut_cut (
    .clk(clk), .rst_n(rst_n), .src_hcount(src_hcount), .src_vcount(src_vcount),
    .src_hsync(src_hsync), .src_vsync(src_vsync), .src_hblnk(src_hblnk), .src_vblnk(src_vblnk),
    .src_rgb(src_rgb), .sel_req(sel_req_c), .sel_valid(sel_valid_c), .sel_ready(c_ready),
    .out_hcount(c_hcount), .out_vcount(c_vcount), .out_hsync(c_hsync), .out_vsync(c_vsync),
    .out_hblnk(c_hblnk), .out_vblnk(c_vblnk), .out_rgb(c_rgb), .active_sel(c_active),
    .switching(c_switching));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic frame;
    vb = 1'b1;
    tick;
    vb = 1'b0;
    tick;
    tick;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      src_hcount[i*HW +: HW] = HW'(100 + i);
      src_vcount[i*HW +: HW] = HW'(200 + i);
    end
    tick;
    tick;
    chk("rst_rgb", 32'(a_rgb), 32'h000);
    chk("rst_active", 32'(a_active), 0);
    chk("rst_ready", 32'(a_ready), 1);
    chk("rst_switching", 32'(a_switching), 0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_rgb", 32'(a_rgb), 32'hFFF);
    chk("post_rst_active", 32'(a_active), 0);
    chk("post_rst_ready", 32'(a_ready), 1);
    chk("post_rst_switching", 32'(a_switching), 0);
    chk("post_rst_hcount", 32'(a_hcount), 100);
    sel_req_c = 3'd3;
    sel_valid_c = 1'b1;
    tick;
    sel_valid_c = 1'b0;
    chk("cut_switching", 32'(c_switching), 1);
    chk("cut_ready", 32'(c_ready), 0);
    chk("cut_active_wait", 32'(c_active), 0);
    chk("cut_rgb_wait", 32'(c_rgb), 32'hFFF);
    vb = 1'b1;
    tick;
    chk("cut_active_fb", 32'(c_active), 0);
    chk("cut_rgb_blank", 32'(c_rgb), 32'h000);
    vb = 1'b0;
    tick;
    chk("cut_active_done", 32'(c_active), 3);
    chk("cut_switching_done", 32'(c_switching), 0);
    chk("cut_ready_done", 32'(c_ready), 1);
    tick;
    chk("cut_rgb_new", 32'(c_rgb), 32'h5A3);
    chk("cut_hcount_new", 32'(c_hcount), 103);
    sel_req = 3'd2;
    sel_valid = 1'b1;
    tick;
    sel_valid = 1'b0;
    chk("fade_switching", 32'(a_switching), 1);
    chk("fade_ready", 32'(a_ready), 0);
    frame;
    chk("fo_att1", 32'(a_rgb), 32'h777);
    frame;
    chk("fo_att2", 32'(a_rgb), 32'h333);
    frame;
    chk("fo_att3", 32'(a_rgb), 32'h111);
    chk("fo_active_old", 32'(a_active), 0);
    frame;
    chk("fo_att4", 32'(a_rgb), 32'h000);
    chk("swap_active", 32'(a_active), 2);
    chk("swap_hcount", 32'(a_hcount), 102);
    chk("swap_hsync", 32'(a_hsync), 1);
    chk("swap_switching", 32'(a_switching), 1);
    frame;
    chk("fi_att3", 32'(a_rgb), 32'h111);
    frame;
    chk("fi_att2", 32'(a_rgb), 32'h222);
    frame;
    chk("fi_att1", 32'(a_rgb), 32'h444);
    frame;
    chk("fi_att0", 32'(a_rgb), 32'h888);
    chk("fi_switching", 32'(a_switching), 0);
    chk("fi_ready", 32'(a_ready), 1);
    sel_req = 3'd2;
    sel_valid = 1'b1;
    tick;
    chk("noop_same_switching", 32'(a_switching), 0);
    chk("noop_same_active", 32'(a_active), 2);
    chk("noop_same_ready", 32'(a_ready), 1);
    sel_req = 3'd7;
    tick;
    sel_valid = 1'b0;
    chk("noop_range_switching", 32'(a_switching), 0);
    chk("noop_range_active", 32'(a_active), 2);
    chk("noop_range_ready", 32'(a_ready), 1);
    sel_req = 3'd4;
    sel_valid = 1'b1;
    tick;
    sel_valid = 1'b0;
    repeat (4) frame;
    chk("stall_active", 32'(a_active), 4);
    chk("stall_rgb_att4", 32'(a_rgb), 32'h000);
    sel_req = 3'd1;
    sel_valid = 1'b1;
    tick;
    chk("stall_ready0", 32'(a_ready), 0);
    repeat (3) frame;
    chk("stall_ready1", 32'(a_ready), 0);
    chk("stall_rgb_att1", 32'(a_rgb), 32'h011);
    vb = 1'b1;
    tick;
    chk("stall_idle_ready", 32'(a_ready), 1);
    chk("stall_idle_switching", 32'(a_switching), 0);
    vb = 1'b0;
    tick;
    sel_valid = 1'b0;
    chk("stall_accept_switching", 32'(a_switching), 1);
    chk("stall_accept_ready", 32'(a_ready), 0);
    tick;
    chk("stall_rgb_full", 32'(a_rgb), 32'h123);
    frame;
    chk("fo2_att1", 32'(a_rgb), 32'h011);
    frame;
    chk("fo2_att2", 32'(a_rgb), 32'h000);
    chk("fo2_active", 32'(a_active), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rgb", 32'(a_rgb), 32'h000);
    chk("async_hcount", 32'(a_hcount), 0);
    chk("async_active", 32'(a_active), 0);
    chk("async_switching", 32'(a_switching), 0);
    chk("async_ready", 32'(a_ready), 1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rerst_rgb", 32'(a_rgb), 32'hFFF);
    chk("rerst_active", 32'(a_active), 0);
    chk("rerst_ready", 32'(a_ready), 1);
    frame;
    chk("rerst_frame_rgb", 32'(a_rgb), 32'hFFF);
    chk("rerst_frame_switching", 32'(a_switching), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
